coh_acq_tracker: RTL and testbench

Parametrised successor to the single-transaction Acquire state machine in the coherence manager. It tracks up to NUM_SLOTS outstanding TileLink Acquire→Grant→GrantAck transactions, each keyed by the Acquire source ID. It serialises Acquire and GrantAck generation requests to the TL logic, matches incoming Grants to slots by source, and adds a per-slot Grant timeout. It sits between the TL logic (TX Acquire/E-channel generation) and TL RX (Grant reception).

---
 rtl/coh_acq_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_coh_acq_tracker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coh_acq_tracker.sv
// Multi-slot Acquire -> Grant -> GrantAck tracker for the coherence manager.
// Slots are keyed by source ID; Acquire and GrantAck generation are serialised.
module coh_acq_tracker #(
    parameter int NUM_SLOTS = 4,
    parameter int SRC_W     = 26,
    parameter int SINK_W    = 26,
    parameter int TIMEOUT   = 1024,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              acq_req_valid,
    input  logic [SRC_W-1:0]  acq_req_source,
    output logic              acq_req_ready,
    output logic              acq_gen_en,
    output logic [SRC_W-1:0]  acq_gen_source,
    input  logic              acq_gen_done,
    input  logic              rcv_gnt,
    input  logic [SRC_W-1:0]  rcv_gnt_source,
    input  logic [SINK_W-1:0] rcv_gnt_sink,
    output logic              rcv_gnt_ack,
    output logic              gnt_err,
    output logic              gntack_gen_en,
    output logic [SINK_W-1:0] e_sink,
    input  logic              gntack_gen_done,
    output logic              timeout,
    output logic [SLOT_W-1:0] timeout_slot,
    output logic [SLOT_W:0]   outstanding
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_WAIT,
        S_ACK
    } slot_st_e;

    slot_st_e          st_q   [NUM_SLOTS];
    slot_st_e          st_d   [NUM_SLOTS];
    logic [SRC_W-1:0]  src_q  [NUM_SLOTS];
    logic [SRC_W-1:0]  src_d  [NUM_SLOTS];
    logic [SINK_W-1:0] sink_q [NUM_SLOTS];
    logic [SINK_W-1:0] sink_d [NUM_SLOTS];
    logic [CNT_W-1:0]  cnt_q  [NUM_SLOTS];
    logic [CNT_W-1:0]  cnt_d  [NUM_SLOTS];

    logic              gen_vld_q, gen_vld_d;
    logic [SLOT_W-1:0] gen_idx_q, gen_idx_d;
    logic              ack_vld_q, ack_vld_d;
    logic [SLOT_W-1:0] ack_idx_q, ack_idx_d;
    logic              gnt_ack_q, gnt_ack_d;
    logic              gnt_err_q, gnt_err_d;
    logic              to_q, to_d;
    logic [SLOT_W-1:0] to_slot_q, to_slot_d;
    logic [SLOT_W:0]   outst_q, outst_d;

    logic free_hit, dup_hit, alloc_done, gnt_hit;

    always_comb begin
        free_hit = 1'b0;
        dup_hit  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (st_q[i] == S_IDLE) free_hit = 1'b1;
            else if (src_q[i] == acq_req_source) dup_hit = 1'b1;
        end
    end

    assign acq_req_ready = free_hit && !dup_hit;

    always_comb begin
        st_d       = st_q;
        src_d      = src_q;
        sink_d     = sink_q;
        cnt_d      = cnt_q;
        gen_vld_d  = gen_vld_q;
        gen_idx_d  = gen_idx_q;
        ack_vld_d  = ack_vld_q;
        ack_idx_d  = ack_idx_q;
        alloc_done = 1'b0;
        gnt_hit    = 1'b0;
        to_d       = 1'b0;
        to_slot_d  = '0;
        outst_d    = '0;

        if (acq_req_valid && acq_req_ready) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!alloc_done && st_q[i] == S_IDLE) begin
                    alloc_done = 1'b1;
                    st_d[i]    = S_GEN;
                    src_d[i]   = acq_req_source;
                end
            end
        end

        // Selection stays put until done, then idles one cycle before re-picking.
        if (gen_vld_q) begin
            if (acq_gen_done) begin
                st_d[gen_idx_q]  = S_WAIT;
                cnt_d[gen_idx_q] = '0;
                gen_vld_d        = 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!gen_vld_d && st_q[i] == S_GEN) begin
                    gen_vld_d = 1'b1;
                    gen_idx_d = SLOT_W'(i);
                end
            end
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rcv_gnt && !gnt_hit && st_q[i] == S_WAIT &&
                src_q[i] == rcv_gnt_source) begin
                gnt_hit   = 1'b1;
                st_d[i]   = S_ACK;
                sink_d[i] = rcv_gnt_sink;
            end
        end
        gnt_ack_d = rcv_gnt && gnt_hit;
        gnt_err_d = rcv_gnt && !gnt_hit;

        if (ack_vld_q) begin
            if (gntack_gen_done) begin
                st_d[ack_idx_q] = S_IDLE;
                ack_vld_d       = 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!ack_vld_d && st_q[i] == S_ACK) begin
                    ack_vld_d = 1'b1;
                    ack_idx_d = SLOT_W'(i);
                end
            end
        end

        // One expiry reported per cycle; later ones hold at the limit.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (st_q[i] == S_WAIT && st_d[i] == S_WAIT) begin
                if (TIMEOUT > 0 && cnt_q[i] == CNT_LAST) begin
                    if (!to_d) begin
                        to_d      = 1'b1;
                        to_slot_d = SLOT_W'(i);
                        st_d[i]   = S_IDLE;
                    end
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (st_q[i] != S_IDLE) outst_d = outst_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                st_q[i]   <= S_IDLE;
                src_q[i]  <= '0;
                sink_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            gen_vld_q <= 1'b0;
            gen_idx_q <= '0;
            ack_vld_q <= 1'b0;
            ack_idx_q <= '0;
            gnt_ack_q <= 1'b0;
            gnt_err_q <= 1'b0;
            to_q      <= 1'b0;
            to_slot_q <= '0;
            outst_q   <= '0;
        end else begin
            st_q      <= st_d;
            src_q     <= src_d;
            sink_q    <= sink_d;
            cnt_q     <= cnt_d;
            gen_vld_q <= gen_vld_d;
            gen_idx_q <= gen_idx_d;
            ack_vld_q <= ack_vld_d;
            ack_idx_q <= ack_idx_d;
            gnt_ack_q <= gnt_ack_d;
            gnt_err_q <= gnt_err_d;
            to_q      <= to_d;
            to_slot_q <= to_slot_d;
            outst_q   <= outst_d;
        end
    end

    assign acq_gen_en     = gen_vld_q;
    assign acq_gen_source = gen_vld_q ? src_q[gen_idx_q] : '0;
    assign gntack_gen_en  = ack_vld_q;
    assign e_sink         = ack_vld_q ? sink_q[ack_idx_q] : '0;
    assign rcv_gnt_ack    = gnt_ack_q;
    assign gnt_err        = gnt_err_q;
    assign timeout        = to_q;
    assign timeout_slot   = to_slot_q;
    assign outstanding    = outst_q;

endmodule

// File: tb/tb_coh_acq_tracker.sv
// Directed scoreboard bench for coh_acq_tracker (4 slots, 8-cycle timeout).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_coh_acq_tracker;

    localparam int SRC_W  = 26;
    localparam int SINK_W = 26;
    localparam int NSL    = 4;
    localparam int SW     = 2;

    logic              clk = 1'b0;
    logic              reset_;
    logic              acq_req_valid;
    logic [SRC_W-1:0]  acq_req_source;
    logic              acq_req_ready;
    logic              acq_gen_en;
    logic [SRC_W-1:0]  acq_gen_source;
    logic              acq_gen_done;
    logic              rcv_gnt;
    logic [SRC_W-1:0]  rcv_gnt_source;
    logic [SINK_W-1:0] rcv_gnt_sink;
    logic              rcv_gnt_ack;
    logic              gnt_err;
    logic              gntack_gen_en;
    logic [SINK_W-1:0] e_sink;
    logic              gntack_gen_done;
    logic              timeout;
    logic [SW-1:0]     timeout_slot;
    logic [SW:0]       outstanding;

    int checks   = 0;
    int failures = 0;

    logic [SRC_W-1:0]  exp_gen  [$];
    logic [SINK_W-1:0] exp_sink [$];

    always #5 clk = ~clk;

    coh_acq_tracker #(
        .NUM_SLOTS(NSL),
        .SRC_W    (SRC_W),
        .SINK_W   (SINK_W),
        .TIMEOUT  (8)
    ) dut (
        .clk            (clk),
        .reset_         (reset_),
        .acq_req_valid  (acq_req_valid),
        .acq_req_source (acq_req_source),
        .acq_req_ready  (acq_req_ready),
        .acq_gen_en     (acq_gen_en),
        .acq_gen_source (acq_gen_source),
        .acq_gen_done   (acq_gen_done),
        .rcv_gnt        (rcv_gnt),
        .rcv_gnt_source (rcv_gnt_source),
        .rcv_gnt_sink   (rcv_gnt_sink),
        .rcv_gnt_ack    (rcv_gnt_ack),
        .gnt_err        (gnt_err),
        .gntack_gen_en  (gntack_gen_en),
        .e_sink         (e_sink),
        .gntack_gen_done(gntack_gen_done),
        .timeout        (timeout),
        .timeout_slot   (timeout_slot),
        .outstanding    (outstanding)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        tick();
        acq_req_valid   = 1'b0;
        acq_req_source  = '0;
        acq_gen_done    = 1'b0;
        rcv_gnt         = 1'b0;
        rcv_gnt_source  = '0;
        rcv_gnt_sink    = '0;
        gntack_gen_done = 1'b0;
        exp_gen.delete();
        exp_sink.delete();
        tick();
        reset_ = 1'b1;
        #1;
        chk("rst_ready",   32'(acq_req_ready), 32'd1);
        chk("rst_gen_en",  32'(acq_gen_en), 32'd0);
        chk("rst_gen_src", 32'(acq_gen_source), 32'd0);
        chk("rst_gnt_ack", 32'(rcv_gnt_ack), 32'd0);
        chk("rst_gnt_err", 32'(gnt_err), 32'd0);
        chk("rst_gack_en", 32'(gntack_gen_en), 32'd0);
        chk("rst_e_sink",  32'(e_sink), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_to_slot", 32'(timeout_slot), 32'd0);
        chk("rst_outst",   32'(outstanding), 32'd0);
    endtask

    task automatic req(input logic [SRC_W-1:0] s);
        acq_req_valid  = 1'b1;
        acq_req_source = s;
        #1;
        chk("req_ready", 32'(acq_req_ready), 32'd1);
        tick();
        acq_req_valid = 1'b0;
    endtask

    task automatic wait_gen(output int lat);
        lat = 0;
        while (acq_gen_en !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("gen_en_seen", 32'(acq_gen_en), 32'd1);
    endtask

    task automatic gen_done();
        int l;
        wait_gen(l);
        chk("gen_sb_nonempty", 32'(exp_gen.size() > 0), 32'd1);
        if (exp_gen.size() > 0)
            chk("gen_source", 32'(acq_gen_source), 32'(exp_gen.pop_front()));
        acq_gen_done = 1'b1;
        tick();
        acq_gen_done = 1'b0;
        chk("gen_en_drop", 32'(acq_gen_en), 32'd0);
    endtask

    task automatic grant(input logic [SRC_W-1:0] s,
                         input logic [SINK_W-1:0] k, input bit hit);
        rcv_gnt        = 1'b1;
        rcv_gnt_source = s;
        rcv_gnt_sink   = k;
        tick();
        rcv_gnt = 1'b0;
        chk("gnt_ack", 32'(rcv_gnt_ack), 32'(hit));
        chk("gnt_err", 32'(gnt_err), 32'(!hit));
        if (hit) exp_sink.push_back(k);
    endtask

    task automatic gack();
        int n = 0;
        while (gntack_gen_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("gack_en_seen", 32'(gntack_gen_en), 32'd1);
        chk("gack_sb_nonempty", 32'(exp_sink.size() > 0), 32'd1);
        if (exp_sink.size() > 0)
            chk("gack_e_sink", 32'(e_sink), 32'(exp_sink.pop_front()));
        gntack_gen_done = 1'b1;
        tick();
        gntack_gen_done = 1'b0;
        chk("gack_en_drop", 32'(gntack_gen_en), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c;
        logic seen;

        acq_req_valid   = 1'b0;
        acq_req_source  = '0;
        acq_gen_done    = 1'b0;
        rcv_gnt         = 1'b0;
        rcv_gnt_source  = '0;
        rcv_gnt_sink    = '0;
        gntack_gen_done = 1'b0;
        do_reset();

        // single flow, including a Grant that hits a slot still in GEN
        req(26'h5);
        exp_gen.push_back(26'h5);
        wait_gen(lat);
        chk("sf_gen_latency", 32'(lat), 32'd1);
        grant(26'h5, 26'h99, 1'b0);
        gen_done();
        grant(26'h5, 26'h2A, 1'b1);
        chk("sf_outst_busy", 32'(outstanding), 32'd1);
        gack();
        tick();
        tick();
        chk("sf_outst_idle", 32'(outstanding), 32'd0);

        // fill and back-pressure
        do_reset();
        req(26'h1);
        req(26'h2);
        req(26'h3);
        req(26'h4);
        acq_req_valid  = 1'b1;
        acq_req_source = 26'h5;
        #1;
        chk("fill_ready_full", 32'(acq_req_ready), 32'd0);
        repeat (3) begin
            tick();
            chk("fill_ready_hold", 32'(acq_req_ready), 32'd0);
        end
        chk("fill_outst", 32'(outstanding), 32'd4);
        acq_req_valid = 1'b0;
        exp_gen.push_back(26'h1);
        gen_done();
        grant(26'h1, 26'h11, 1'b1);
        #1;
        chk("fill_ready_ack", 32'(acq_req_ready), 32'd0);
        gack();
        req(26'h5);
        exp_gen.push_back(26'h2);
        exp_gen.push_back(26'h5);
        gen_done();
        gen_done();

        // duplicate source
        do_reset();
        req(26'h7);
        exp_gen.push_back(26'h7);
        gen_done();
        acq_req_valid  = 1'b1;
        acq_req_source = 26'h8;
        #1;
        chk("dup_other_ready", 32'(acq_req_ready), 32'd1);
        acq_req_source = 26'h7;
        #1;
        chk("dup_ready_wait", 32'(acq_req_ready), 32'd0);
        grant(26'h7, 26'h70, 1'b1);
        #1;
        chk("dup_ready_ack", 32'(acq_req_ready), 32'd0);
        gack();
        #1;
        chk("dup_ready_free", 32'(acq_req_ready), 32'd1);
        exp_gen.push_back(26'h7);
        tick();
        acq_req_valid = 1'b0;
        wait_gen(lat);
        chk("dup_gen_latency", 32'(lat), 32'd1);
        gen_done();

        // out-of-order Grants
        do_reset();
        req(26'h1);
        req(26'h2);
        req(26'h3);
        exp_gen.push_back(26'h1);
        exp_gen.push_back(26'h2);
        exp_gen.push_back(26'h3);
        gen_done();
        gen_done();
        gen_done();
        grant(26'h3, 26'h33, 1'b1);
        grant(26'h1, 26'h11, 1'b1);
        grant(26'h2, 26'h22, 1'b1);
        grant(26'h9, 26'h99, 1'b0);
        chk("ooo_outst", 32'(outstanding), 32'd3);
        gack();
        gack();
        gack();
        tick();
        tick();
        chk("ooo_outst_idle", 32'(outstanding), 32'd0);

        // timeout, then Grant on the expiry cycle
        do_reset();
        req(26'hA);
        exp_gen.push_back(26'hA);
        gen_done();
        c = 0;
        while (timeout !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        chk("to_latency", 32'(c), 32'd8);
        chk("to_slot", 32'(timeout_slot), 32'd0);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'd0);
        chk("to_outst", 32'(outstanding), 32'd0);
        req(26'hB);
        exp_gen.push_back(26'hB);
        gen_done();
        repeat (7) tick();
        grant(26'hB, 26'h3C, 1'b1);
        chk("to_race_no_to", 32'(timeout), 32'd0);
        tick();
        chk("to_race_no_to2", 32'(timeout), 32'd0);
        gack();

        // reset with three slots busy and done pulses pending
        req(26'h1);
        req(26'h2);
        req(26'h3);
        exp_gen.push_back(26'h1);
        gen_done();
        acq_gen_done    = 1'b1;
        gntack_gen_done = 1'b1;
        do_reset();
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen = seen | timeout | gnt_err | rcv_gnt_ack | acq_gen_en | gntack_gen_en;
        end
        chk("mid_rst_quiet", 32'(seen), 32'd0);
        chk("mid_rst_outst", 32'(outstanding), 32'd0);
        chk("mid_rst_ready", 32'(acq_req_ready), 32'd1);

        chk("sb_gen_empty", 32'(exp_gen.size()), 32'd0);
        chk("sb_sink_empty", 32'(exp_sink.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
